// File: rtl/toggle_cover_sink.sv
// Toggle-coverage sink: records hit bits stickily and reports each newly covered point once as an absolute index.
// Optional define TOGGLE_SINK_COUNT_EN enables the hit_count handshake counter (tied to 0 otherwise).
module toggle_cover_sink #(
    parameter int              WIDTH       = 43,
    parameter longint unsigned COVER_INDEX = 0,
    parameter int              IDX_W       = 64,
    parameter int              CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] valid,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             all_covered,
    output logic [CNT_W-1:0] hit_count,
    output logic             dbg_state
);

    localparam int CUR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] reported;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_rest;
    logic [WIDTH-1:0] cur_onehot;
    logic [CUR_W-1:0] cur;
    logic [CUR_W-1:0] cur_nxt;
    logic             handshake;

    // Lowest set bit wins; bit 0 has the highest priority.
    function automatic logic [CUR_W-1:0] lowest(input logic [WIDTH-1:0] v);
        logic [CUR_W-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) idx = CUR_W'(i);
        end
        return idx;
    endfunction

    // Stream handshake: out_valid/out_index stay stable until a cycle where
    // out_valid && out_ready; that cycle transfers exactly one index.
    always_comb begin
        cur_onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cur_onehot[i] = (cur == CUR_W'(i));
        end
    end

    assign pending      = hit & ~reported;
    assign pending_rest = pending & ~cur_onehot;
    assign handshake    = (state == PRESENT) && out_ready;

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        case (state)
            IDLE: begin
                if (|pending) begin
                    cur_nxt   = lowest(pending);
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (handshake) begin
                    if (|pending_rest) begin
                        cur_nxt = lowest(pending_rest);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // clear outranks both a same-cycle handshake and same-cycle hits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hit      <= '0;
            reported <= '0;
            cur      <= '0;
        end else if (clear) begin
            state    <= IDLE;
            hit      <= '0;
            reported <= '0;
            cur      <= '0;
        end else begin
            state <= state_nxt;
            hit   <= hit | valid;
            cur   <= cur_nxt;
            if (handshake) begin
                reported <= reported | cur_onehot;
            end
        end
    end

    assign out_valid   = (state == PRESENT);
    assign out_index   = (state == PRESENT) ? (IDX_W'(COVER_INDEX) + IDX_W'(cur)) : '0;
    assign all_covered = &hit;
    assign dbg_state   = state;

`ifdef TOGGLE_SINK_COUNT_EN
    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (handshake && (count != CNT_W'(WIDTH))) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hit_count = count;
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_toggle_cover_sink.sv
// Directed bench for toggle_cover_sink (WIDTH=43, COVER_INDEX=1000) with immediate-assertion checks.
module tb_toggle_cover_sink;

  localparam int WIDTH = 43;
  localparam longint unsigned BASE = 1000;
  localparam int IDX_W = 64;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef TOGGLE_SINK_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [WIDTH-1:0] valid = '0;
  logic             clear = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [IDX_W-1:0] out_index;
  logic             all_covered;
  logic [CNT_W-1:0] hit_count;
  logic             dbg_state;

  int checks = 0;
  int errors = 0;

  toggle_cover_sink #(
    .WIDTH(WIDTH),
    .COVER_INDEX(BASE),
    .IDX_W(IDX_W),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .valid(valid),
    .clear(clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .all_covered(all_covered),
    .hit_count(hit_count),
    .dbg_state(dbg_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int n);
    return CNT_ON ? 64'(n) : 64'd0;
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [WIDTH-1:0] v;

  initial begin
    // reset state
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_index", out_index, 64'd0);
    check("rst_all_covered", 64'(all_covered), 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    out_ready = 1'b1;

    // single hit: bit 0 -> index 1000 two cycles later, gone the cycle after
    valid = 43'h1;
    tick();
    valid = '0;
    check("t1_c1_valid", 64'(out_valid), 64'd0);
    tick();
    check("t1_c2_valid", 64'(out_valid), 64'd1);
    check("t1_c2_index", out_index, 64'd1000);
    tick();
    check("t1_c3_valid", 64'(out_valid), 64'd0);
    check("t1_count", 64'(hit_count), exp_cnt(1));

    // three simultaneous hits drain back-to-back in priority order
    do_clear();
    check("t2_clr_count", 64'(hit_count), 64'd0);
    v = '0;
    v[42] = 1'b1;
    v[5] = 1'b1;
    v[0] = 1'b1;
    valid = v;
    tick();
    valid = '0;
    tick();
    check("t2_v0", 64'(out_valid), 64'd1);
    check("t2_i0", out_index, 64'd1000);
    tick();
    check("t2_v1", 64'(out_valid), 64'd1);
    check("t2_i1", out_index, 64'd1005);
    tick();
    check("t2_v2", 64'(out_valid), 64'd1);
    check("t2_i2", out_index, 64'd1042);
    tick();
    check("t2_end", 64'(out_valid), 64'd0);
    v = '0;
    v[5] = 1'b1;
    valid = v;
    tick();
    valid = '0;
    tick();
    check("t2_rehit_a", 64'(out_valid), 64'd0);
    tick();
    check("t2_rehit_b", 64'(out_valid), 64'd0);
    check("t2_count", 64'(hit_count), exp_cnt(3));

    // backpressure: presented 1003 is not preempted by a later lower hit
    do_clear();
    out_ready = 1'b0;
    v = '0;
    v[3] = 1'b1;
    valid = v;
    tick();
    valid = '0;
    tick();
    check("t3_v", 64'(out_valid), 64'd1);
    check("t3_i", out_index, 64'd1003);
    v = '0;
    v[1] = 1'b1;
    valid = v;
    tick();
    valid = '0;
    for (int i = 0; i < 4; i++) begin
      check("t3_hold_v", 64'(out_valid), 64'd1);
      check("t3_hold_i", out_index, 64'd1003);
      tick();
    end
    check("t3_hold_last", out_index, 64'd1003);
    out_ready = 1'b1;
    tick();
    check("t3_next_v", 64'(out_valid), 64'd1);
    check("t3_next_i", out_index, 64'd1001);
    tick();
    check("t3_end", 64'(out_valid), 64'd0);
    check("t3_count", 64'(hit_count), exp_cnt(2));

    // full coverage and full drain
    do_clear();
    out_ready = 1'b0;
    check("t4_cov_before", 64'(all_covered), 64'd0);
    valid = '1;
    tick();
    valid = '0;
    check("t4_cov_after", 64'(all_covered), 64'd1);
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < WIDTH; i++) begin
      check("t4_drain_v", 64'(out_valid), 64'd1);
      check("t4_drain_i", out_index, 64'(BASE) + 64'(i));
      tick();
    end
    check("t4_end", 64'(out_valid), 64'd0);
    check("t4_cov_hold", 64'(all_covered), 64'd1);
    check("t4_count", 64'(hit_count), exp_cnt(43));

    // clear beats a same-cycle handshake and same-cycle hit
    do_clear();
    check("t5_cov_clr", 64'(all_covered), 64'd0);
    out_ready = 1'b0;
    v = '0;
    v[7] = 1'b1;
    valid = v;
    tick();
    valid = '0;
    tick();
    check("t5_i", out_index, 64'd1007);
    out_ready = 1'b1;
    clear = 1'b1;
    v = '0;
    v[9] = 1'b1;
    valid = v;
    tick();
    clear = 1'b0;
    valid = '0;
    check("t5_clr_v", 64'(out_valid), 64'd0);
    check("t5_clr_count", 64'(hit_count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no1009", 64'(out_valid), 64'd0);
    end
    v = '0;
    v[7] = 1'b1;
    valid = v;
    tick();
    valid = '0;
    tick();
    check("t5_re_v", 64'(out_valid), 64'd1);
    check("t5_re_i", out_index, 64'd1007);
    tick();
    check("t5_re_end", 64'(out_valid), 64'd0);
    check("t5_count", 64'(hit_count), exp_cnt(1));

    // asynchronous reset while presenting 1020
    out_ready = 1'b0;
    v = '0;
    v[20] = 1'b1;
    valid = v;
    tick();
    valid = '0;
    tick();
    check("t6_i", out_index, 64'd1020);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_v", 64'(out_valid), 64'd0);
    check("t6_async_i", out_index, 64'd0);
    check("t6_async_state", 64'(dbg_state), 64'd0);
    valid = '1;
    tick();
    tick();
    valid = '0;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_post_v", 64'(out_valid), 64'd0);
      check("t6_post_cov", 64'(all_covered), 64'd0);
    end
    check("t6_count", 64'(hit_count), 64'd0);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
